// File: rtl/mem32k_ctrl_pkg.sv
// Shared definitions for the 32Kx8 asynchronous SRAM controller:
// bus widths, default timing, FSM state encodings and the strobe decode.
package mem32k_ctrl_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    // Default phase lengths in clock cycles
    localparam int unsigned DEF_RD_WAIT = 2;
    localparam int unsigned DEF_WR_WAIT = 2;
    localparam int unsigned DEF_TURN    = 1;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_SETUP  = 3'd1;
    localparam logic [2:0] ST_RD_STROBE = 3'd2;
    localparam logic [2:0] ST_RD_END    = 3'd3;
    localparam logic [2:0] ST_TURN      = 3'd4;
    localparam logic [2:0] ST_WR_SETUP  = 3'd5;
    localparam logic [2:0] ST_WR_STROBE = 3'd6;
    localparam logic [2:0] ST_WR_HOLD   = 3'd7;

    // SRAM pin levels plus the data-bus drive enable for one FSM state
    typedef struct packed {
        logic cs_n;
        logic oe_n;
        logic we_n;
        logic drive;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{cs_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, drive: 1'b0};

    // OE_N is only ever low in RD_STROBE, where neither WE_N nor the bus drive is active.
    function automatic strobe_t strobes_of(input logic [2:0] st);
        strobe_t s;
        s = STROBE_IDLE;
        case (st)
            ST_RD_SETUP:  s.cs_n = 1'b0;
            ST_RD_STROBE: begin s.cs_n = 1'b0; s.oe_n = 1'b0; end
            ST_WR_SETUP:  begin s.cs_n = 1'b0; s.drive = 1'b1; end
            ST_WR_STROBE: begin s.cs_n = 1'b0; s.we_n = 1'b0; s.drive = 1'b1; end
            ST_WR_HOLD:   begin s.cs_n = 1'b0; s.drive = 1'b1; end
            default:      s = STROBE_IDLE;
        endcase
        return s;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mem32k_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. When both ports request, the port that was
// not granted last wins; the last-grant register moves only on grant_en.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       any_req,
    output logic       gnt_idx
);

    logic last_q;

    // Pick the winner for the current request pattern
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt_idx = 1'b0;
        any_req = |req;
        if (req == 2'b11) begin
            gnt_idx = ~last_q;
        end else begin
            gnt_idx = req[1];
        end
    end

    // Remember which port was served last; reset value makes port 0 win first
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (grant_en) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/mem32k_ctrl.sv
// Shares one asynchronous 32Kx8 SRAM between two clocked REQ/ACK requesters
// (port 0: hash core, port 1: host loader). All SRAM strobes and the bus
// drive enable are registered so they never glitch and fall back to their
// idle levels immediately on reset.
module mem32k_ctrl
    import mem32k_ctrl_pkg::*;
#(
    parameter int unsigned RD_WAIT = DEF_RD_WAIT,
    parameter int unsigned WR_WAIT = DEF_WR_WAIT,
    parameter int unsigned TURN    = DEF_TURN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_a,
    inout  wire  [DATA_W-1:0] mem_io,
    output logic              mem_cs_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    localparam int unsigned MAX_WAIT = max3(RD_WAIT, WR_WAIT, TURN);
    localparam int          CNT_W    = $clog2(MAX_WAIT) + 1;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_load;
    logic              cnt_done;
    logic              grant_en, any_req, gnt_idx;
    logic              gnt_q;
    logic              sel_we;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [DATA_W-1:0] wdata_q, sel_wdata;
    logic              ack_state;
    strobe_t           strobe_q;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      ({req1, req0}),
        .grant_en (grant_en),
        .any_req  (any_req),
        .gnt_idx  (gnt_idx)
    );

    assign sel_we    = gnt_idx ? we1    : we0;
    assign sel_addr  = gnt_idx ? addr1  : addr0;
    assign sel_wdata = gnt_idx ? wdata1 : wdata0;
    assign cnt_done  = (cnt_q == '0);
    assign ack_state = (state_d == ST_RD_END) || (state_d == ST_WR_HOLD);

    // Next-state logic and the wait-counter value loaded on entry to a timed phase
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        cnt_load = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_en = 1'b1;
                    state_d  = sel_we ? ST_WR_SETUP : ST_RD_SETUP;
                end
            end
            ST_RD_SETUP:  state_d = ST_RD_STROBE;
            ST_RD_STROBE: if (cnt_done) state_d = ST_RD_END;
            ST_RD_END:    state_d = ST_TURN;
            ST_TURN:      if (cnt_done) state_d = ST_IDLE;
            ST_WR_SETUP:  state_d = ST_WR_STROBE;
            ST_WR_STROBE: if (cnt_done) state_d = ST_WR_HOLD;
            ST_WR_HOLD:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_RD_STROBE: cnt_load = CNT_W'(RD_WAIT - 1);
            ST_WR_STROBE: cnt_load = CNT_W'(WR_WAIT - 1);
            ST_TURN:      cnt_load = CNT_W'(TURN - 1);
            default:      cnt_load = '0;
        endcase
    end

    // FSM, wait counter, winner's request latch, registered strobes/ACK/RDATA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gnt_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= STROBE_IDLE;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata    <= '0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                cnt_q <= cnt_load;
            end else if (!cnt_done) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (grant_en) begin
                gnt_q   <= gnt_idx;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end

            strobe_q <= strobes_of(state_d);
            ack0     <= ack_state && !gnt_q;
            ack1     <= ack_state &&  gnt_q;

            // Sample the SRAM at the edge that ends the last OE_N-low cycle
            if (state_q == ST_RD_STROBE && cnt_done) begin
                rdata <= mem_io;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign mem_a    = addr_q;
    assign mem_cs_n = strobe_q.cs_n;
    assign mem_oe_n = strobe_q.oe_n;
    assign mem_we_n = strobe_q.we_n;
    assign mem_io   = strobe_q.drive ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem32k_ctrl.sv
// Directed bench for mem32k_ctrl: a default-timing instance shared by both
// ports plus an RD_WAIT=1 / WR_WAIT=4 instance, each with a behavioural SRAM.
module tb_mem32k_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // default-timing instance
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [14:0] addr0 = 0, addr1 = 0;
    logic [7:0]  wdata0 = 0, wdata1 = 0;
    logic        ack0, ack1, busy, mem_cs_n, mem_oe_n, mem_we_n;
    logic [7:0]  rdata;
    logic [14:0] mem_a;
    wire  [7:0]  mem_io;

    // swept-timing instance (port 0 only)
    logic        b_req0 = 0, b_we0 = 0;
    logic [14:0] b_addr0 = 0;
    logic [7:0]  b_wdata0 = 0;
    logic        b_ack0, b_ack1, b_busy, b_cs_n, b_oe_n, b_we_n;
    logic [7:0]  b_rdata;
    logic [14:0] b_mem_a;
    wire  [7:0]  b_mem_io;

    bit [7:0] sram1 [0:32767];
    bit [7:0] sram2 [0:32767];

    int n_checks = 0;
    int n_pass   = 0;

    int oe_lo1 = 0, we_lo1 = 0, viol1 = 0, since_oe1 = 100;
    int oe_lo2 = 0, we_lo2 = 0, viol2 = 0;
    logic        cs_prev1 = 1'b1;
    logic [14:0] a_prev1 = '0;

    always #5 clk = ~clk;

    mem32k_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_a(mem_a), .mem_io(mem_io),
        .mem_cs_n(mem_cs_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
    );

    mem32k_ctrl #(.RD_WAIT(1), .WR_WAIT(4), .TURN(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .req1(1'b0), .we0(b_we0), .we1(1'b0),
        .addr0(b_addr0), .addr1(15'h0), .wdata0(b_wdata0), .wdata1(8'h00),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy),
        .mem_a(b_mem_a), .mem_io(b_mem_io),
        .mem_cs_n(b_cs_n), .mem_oe_n(b_oe_n), .mem_we_n(b_we_n)
    );

    // Behavioural asynchronous SRAMs: drive on CS+OE with WE high, capture while WE low
    assign mem_io   = (!mem_cs_n && !mem_oe_n && mem_we_n) ? sram1[mem_a]   : 8'hzz;
    assign b_mem_io = (!b_cs_n   && !b_oe_n   && b_we_n)   ? sram2[b_mem_a] : 8'hzz;

    always @(posedge clk) begin
        if (!mem_cs_n && !mem_we_n) sram1[mem_a] <= mem_io;
        if (!b_cs_n && !b_we_n)     sram2[b_mem_a] <= b_mem_io;
    end

    // Bus-rule monitor for the default instance, sampled on the falling edge
    always @(negedge clk) begin
        if (!mem_oe_n) oe_lo1 <= oe_lo1 + 1;
        if (!mem_we_n) we_lo1 <= we_lo1 + 1;
        if (!mem_oe_n && !mem_we_n) viol1 <= viol1 + 1;
        if (mem_cs_n && mem_io !== 8'hzz) viol1 <= viol1 + 1;
        if (mem_oe_n && mem_io !== 8'hzz && since_oe1 <= 1) viol1 <= viol1 + 1;
        if (mem_oe_n && mem_io !== 8'hzz && $isunknown(mem_io)) viol1 <= viol1 + 1;
        if (!mem_cs_n && !cs_prev1 && mem_a != a_prev1) viol1 <= viol1 + 1;
        if (ack0 && ack1) viol1 <= viol1 + 1;
        if (!mem_oe_n) since_oe1 <= 0;
        else if (since_oe1 < 100) since_oe1 <= since_oe1 + 1;
        cs_prev1 <= mem_cs_n;
        a_prev1  <= mem_a;
    end

    always @(negedge clk) begin
        if (!b_oe_n) oe_lo2 <= oe_lo2 + 1;
        if (!b_we_n) we_lo2 <= we_lo2 + 1;
        if (!b_oe_n && !b_we_n) viol2 <= viol2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_idle1();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle2();
        int n;
        n = 0;
        @(negedge clk);
        while (b_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One access on the default instance; lat counts edges from accept to ACK (0 = timeout)
    task automatic acc1(input int port, input logic we, input logic [14:0] a,
                        input logic [7:0] d, output logic [7:0] rd, output int lat);
        bit done;
        wait_idle1();
        if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else           begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        lat = 0; rd = '0; done = 0;
        for (int i = 1; i <= 50 && !done; i++) begin
            @(posedge clk); #1;
            if ((port == 0 && ack0) || (port == 1 && ack1)) begin
                done = 1; lat = i; rd = rdata;
            end
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic acc2(input logic we, input logic [14:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
        bit done;
        wait_idle2();
        b_req0 = 1; b_we0 = we; b_addr0 = a; b_wdata0 = d;
        lat = 0; rd = '0; done = 0;
        for (int i = 1; i <= 50 && !done; i++) begin
            @(posedge clk); #1;
            if (b_ack0) begin done = 1; lat = i; rd = b_rdata; end
        end
        b_req0 = 0;
    endtask

    initial begin
        logic [7:0] rd;
        int lat, snap_oe, snap_we, n_ack, first, seen;
        int order[4];
        int exp_ord[4];
        logic [7:0] rd0;

        exp_ord = '{0, 1, 0, 1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst cs_n", mem_cs_n, 1);
        check("rst oe_n", mem_oe_n, 1);
        check("rst we_n", mem_we_n, 1);
        check("rst bus z", mem_io === 8'hzz, 1);
        check("rst ack", {ack0, ack1}, 0);
        check("rst rdata", rdata, 0);
        check("rst mem_a", mem_a, 0);
        check("rst busy", busy, 0);
        rst_n = 1;

        // Write then read on port 0
        snap_oe = oe_lo1;
        acc1(0, 1'b1, 15'h1234, 8'hA5, rd, lat);
        check("wr lat", lat, 4);
        check("wr oe_n low cycles", oe_lo1 - snap_oe, 0);
        snap_oe = oe_lo1;
        acc1(0, 1'b0, 15'h1234, 8'h00, rd, lat);
        check("rd lat", lat, 4);
        check("rd data", rd, 8'hA5);
        check("rd oe_n low cycles", oe_lo1 - snap_oe, 2);

        // Round-robin with both requests held from reset
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 15'h0010; addr1 = 15'h0020;
        order = '{-1, -1, -1, -1};
        n_ack = 0;
        for (int i = 0; i < 100 && n_ack < 4; i++) begin
            @(posedge clk); #1;
            if (ack0 && n_ack < 4) begin order[n_ack] = 0; n_ack++; end
            if (ack1 && n_ack < 4) begin order[n_ack] = 1; n_ack++; end
        end
        req0 = 0; req1 = 0;
        for (int k = 0; k < 4; k++) check($sformatf("rr order %0d", k), order[k], exp_ord[k]);

        // Read/write contention: port 0 reads 0x0000, port 1 writes 0x3C to 0x0001
        wait_idle1();
        req0 = 1; we0 = 0; addr0 = 15'h0000;
        req1 = 1; we1 = 1; addr1 = 15'h0001; wdata1 = 8'h3C;
        first = -1; rd0 = 8'hEE;
        for (int i = 0; i < 60 && (req0 || req1); i++) begin
            @(posedge clk); #1;
            if (ack0) begin if (first < 0) first = 0; rd0 = rdata; req0 = 0; end
            if (ack1) begin if (first < 0) first = 1; req1 = 0; end
        end
        req0 = 0; req1 = 0;
        check("cont first port", first, 0);
        check("cont rd 0x0000", rd0, 8'h00);
        acc1(0, 1'b0, 15'h0001, 8'h00, rd, lat);
        check("cont rd 0x0001", rd, 8'h3C);

        // Boundary address
        acc1(1, 1'b1, 15'h7FFF, 8'hFF, rd, lat);
        check("top wr lat", lat, 4);
        acc1(0, 1'b0, 15'h7FFF, 8'h00, rd, lat);
        check("top rd data", rd, 8'hFF);
        acc1(1, 1'b0, 15'h0000, 8'h00, rd, lat);
        check("zero addr unchanged", rd, 8'h00);

        // Reset in the middle of a write strobe
        wait_idle1();
        req0 = 1; we0 = 1; addr0 = 15'h0100; wdata0 = 8'h77;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (!mem_we_n) seen = 1;
        end
        check("mw strobe seen", seen, 1);
        #2 rst_n = 0;
        #1;
        check("mw cs_n", mem_cs_n, 1);
        check("mw we_n", mem_we_n, 1);
        check("mw oe_n", mem_oe_n, 1);
        check("mw bus z", mem_io === 8'hzz, 1);
        check("mw no ack", ack0, 0);
        check("mw busy", busy, 0);
        req0 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        acc1(0, 1'b0, 15'h7FFF, 8'h00, rd, lat);
        check("post-rst lat", lat, 4);
        check("post-rst data", rd, 8'hFF);

        // Swept timing: RD_WAIT=1, WR_WAIT=4
        snap_oe = oe_lo2; snap_we = we_lo2;
        acc2(1'b1, 15'h0042, 8'h5A, rd, lat);
        check("sweep wr lat", lat, 6);
        check("sweep we_n low cycles", we_lo2 - snap_we, 4);
        check("sweep wr oe_n low cycles", oe_lo2 - snap_oe, 0);
        snap_oe = oe_lo2;
        acc2(1'b0, 15'h0042, 8'h00, rd, lat);
        check("sweep rd lat", lat, 3);
        check("sweep oe_n low cycles", oe_lo2 - snap_oe, 1);
        check("sweep rd data", rd, 8'h5A);

        repeat (3) @(negedge clk);
        check("bus rules dut", viol1, 0);
        check("bus rules dut2", viol2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
